bfa_registered: RTL and testbench
=================================

Name: bfa_registered

Overview:
- Single-bit binary full adder (BFA) cell: adds two operand bits I[1:0] and a carry-in ci, producing sum so and carry-out co.
- Leaf arithmetic cell for ripple-carry adders and for exhaustive gate-level exercise.
- Combinational core is built from explicit gates, wrapped by an optional output register stage with clock and asynchronous reset.

Parameters:
- REG_OUT, 1, 1 = so/co registered (one-cycle latency); 0 = so/co driven combinationally from the core (clk/reset ignored).

Ports:
- clk    input   1  rising-edge clock; used only when REG_OUT=1
- reset  input   1  asynchronous, active-high; clears output registers
- I      input   2  operand bits: I[0] = a, I[1] = b
- ci     input   1  carry-in
- so     output  1  sum bit
- co     output  1  carry-out

Behaviour:
- Core function, pure combinational, gate-level:
  - p = I[0] XOR I[1]
  - g = I[0] AND I[1]
  - sum = p XOR ci
  - carry = g OR (p AND ci)
- Equivalent arithmetic: {carry,sum} = I[0] + I[1] + ci, a 2-bit result in the range 0..3; no overflow is possible.
- Full truth table, indexed by {ci, I[1], I[0]}:
  - 000 -> so=0, co=0
  - 001 -> so=1, co=0
  - 010 -> so=1, co=0
  - 011 -> so=0, co=1
  - 100 -> so=1, co=0
  - 101 -> so=0, co=1
  - 110 -> so=0, co=1
  - 111 -> so=1, co=1
- REG_OUT=0:
  - so = sum and co = carry, with no state.
  - Outputs follow input changes within propagation delay.
  - reset has no effect.
- REG_OUT=1:
  - so/co are flip-flops loaded with sum/carry on every rising clk edge; no enable.
  - Latency is exactly 1 cycle: inputs sampled at edge N appear on so/co after edge N.
  - reset asserted: so=0 and co=0 immediately, independent of clk.
  - reset held high: outputs stay 0 across clock edges.
  - reset deasserted: the first rising edge loads the current sum/carry.
  - Reset asserted mid-stream discards the pending sample. No recovery cycles are needed beyond the next edge.
- X/Z on inputs: no masking is performed; outputs follow gate semantics.
- No internal state other than the two output flops.

Decomposition:
- No shared package is required; the cell has no typedefs or constants.
- One sub-module, bfa_core: purely combinational gate-level full adder (I[1:0], ci -> sum, carry).
- bfa_registered instantiates bfa_core and adds the REG_OUT-selected register stage via a generate block.
- bfa_core is reused directly by ripple-carry chains.

Test Plan:
- REG_OUT=0, 3-bit counter {ci,I[1],I[0]} stepping 0..7 every 50 ns, wrapping to 0 after 7 -> so/co match the truth table at each step (e.g. 3 -> so=0,co=1; 7 -> so=1,co=1); self-check so + 2*co == I[0]+I[1]+ci.
- REG_OUT=1, reset=1 for 100 ns while inputs = 111 -> so=0, co=0 throughout, including across clock edges.
- REG_OUT=1, release reset, apply 101 before edge N -> so=0, co=1 visible only after edge N, not before.
- REG_OUT=1, outputs at so=1,co=1 (input 111); assert reset between edges -> so=co=0 immediately, without waiting for clk.
- REG_OUT=1, back-to-back input changes every cycle (000,011,110,111) -> outputs trail by exactly one cycle: (0,0),(0,1),(0,1),(1,1).
- Randomized 1000 vectors, both REG_OUT values -> compare against the arithmetic model with zero mismatches.

Source files
------------

// File: rtl/bfa_core.sv
// Gate-level single-bit full adder: propagate/generate form, no state.
// Shared by the registered wrapper and by ripple-carry chains.
module bfa_core (
  input  logic [1:0] I,
  input  logic       ci,
  output logic       sum,
  output logic       carry
);

  logic p;
  logic g;
  logic pc;

  xor u_p   (p,     I[0], I[1]);
  and u_g   (g,     I[0], I[1]);
  xor u_sum (sum,   p,    ci);
  and u_pc  (pc,    p,    ci);
  or  u_co  (carry, g,    pc);

endmodule

// File: rtl/bfa_registered.sv
// Full adder cell with an optional output register stage (REG_OUT=1:
// one-cycle latency, async active-high clear; REG_OUT=0: pass-through).
module bfa_registered #(
  parameter int unsigned REG_OUT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] I,
  input  logic       ci,
  output logic       so,
  output logic       co
);

  logic sum;
  logic carry;

  bfa_core u_core (
    .I     (I),
    .ci    (ci),
    .sum   (sum),
    .carry (carry)
  );

  generate
    if (REG_OUT != 0) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          so <= 1'b0;
          co <= 1'b0;
        end else begin
          so <= sum;
          co <= carry;
        end
      end
    end else begin : g_comb
      always_comb begin
        so = sum;
        co = carry;
      end
    end
  endgenerate

endmodule

// File: tb/tb_bfa_registered.sv
// Self-checking bench: combinational and registered instances checked
// against the arithmetic sum a+b+ci and the published truth table.
module tb_bfa_registered;

  logic       clk;
  logic       reset0, reset1;
  logic [1:0] I0, I1;
  logic       ci0, ci1;
  logic       so0, co0, so1, co1;

  int checks = 0;
  int errors = 0;
  logic [1:0] prev;
  logic [7:0] so_tab;
  logic [7:0] co_tab;

  bfa_registered #(.REG_OUT(0)) u_comb (
    .clk(clk), .reset(reset0), .I(I0), .ci(ci0), .so(so0), .co(co0)
  );

  bfa_registered #(.REG_OUT(1)) u_reg (
    .clk(clk), .reset(reset1), .I(I1), .ci(ci1), .so(so1), .co(co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] add3(input logic [2:0] v);
    int unsigned s;
    s = int'(v[0]) + int'(v[1]) + int'(v[2]);
    return s[1:0];
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed co,so=%b expected co,so=%b", tag, obs, exp);
    end
  endtask

  // Drive at negedge; output must still hold the old value, then reflect
  // the new sample only after the following rising edge.
  task automatic rstep(input string tag, input logic r, input logic [2:0] v);
    @(negedge clk);
    reset1 = r;
    {ci1, I1} = v;
    #1;
    if (r) prev = 2'b00;
    chk({tag, "_pre"}, {co1, so1}, prev);
    @(posedge clk);
    #1;
    prev = r ? 2'b00 : add3(v);
    chk({tag, "_post"}, {co1, so1}, prev);
  endtask

  initial begin
    logic [2:0] v;
    logic       r;
    logic [2:0] idx;

    so_tab = 8'b1001_0110;
    co_tab = 8'b1110_1000;
    reset0 = 1'b0;
    reset1 = 1'b1;
    {ci0, I0} = 3'b000;
    {ci1, I1} = 3'b111;
    prev = 2'b00;

    // Combinational instance: counter sweep with wrap, 50 ns per step.
    for (int i = 0; i < 9; i++) begin
      idx = 3'(i);
      {ci0, I0} = idx;
      reset0 = idx[0];
      #50;
      chk("comb_table", {co0, so0}, {co_tab[idx], so_tab[idx]});
      chk("comb_arith", {co0, so0}, add3(idx));
    end

    // Registered instance: reset held for 100 ns with inputs 111.
    for (int i = 0; i < 10; i++) rstep("reset_hold", 1'b1, 3'b111);

    rstep("release_101", 1'b0, 3'b101);
    rstep("load_111", 1'b0, 3'b111);
    chk("before_async", {co1, so1}, 2'b11);

    // Async reset asserted mid-cycle, well before the next rising edge.
    #2;
    reset1 = 1'b1;
    #1;
    prev = 2'b00;
    chk("async_reset", {co1, so1}, 2'b00);

    rstep("b2b_000", 1'b0, 3'b000);
    rstep("b2b_011", 1'b0, 3'b011);
    rstep("b2b_110", 1'b0, 3'b110);
    rstep("b2b_111", 1'b0, 3'b111);

    // Random vectors on both instances, occasional reset on the registered one.
    for (int i = 0; i < 1000; i++) begin
      v = 3'($urandom_range(0, 7));
      {ci0, I0} = 3'($urandom_range(0, 7));
      reset0 = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 15) == 0);
      rstep("rand_reg", r, v);
      chk("rand_comb", {co0, so0}, add3({ci0, I0}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
